// File: rtl/sysid_rom_arb.sv
// Round-robin arbiter and read sequencer sharing one fixed-latency system-ID ROM
// between two pulse-handshake register requesters.
module sysid_rom_arb #(
  parameter int ROM_WIDTH     = 32,
  parameter int ROM_ADDR_BITS = 6,
  parameter int ROM_LATENCY   = 1
) (
  input  logic                     up_clk,
  input  logic                     up_rst,
  input  logic                     req0_rreq,
  input  logic [ROM_ADDR_BITS-1:0] req0_raddr,
  output logic                     req0_rack,
  output logic [ROM_WIDTH-1:0]     req0_rdata,
  input  logic                     req1_rreq,
  input  logic [ROM_ADDR_BITS-1:0] req1_raddr,
  output logic                     req1_rack,
  output logic [ROM_WIDTH-1:0]     req1_rdata,
  output logic [ROM_ADDR_BITS-1:0] rom_addr,
  input  logic [ROM_WIDTH-1:0]     rom_data,
  output logic [1:0]               ovf,
  input  logic [1:0]               ovf_clr,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, CAPTURE = 2'd2} state_t;

  state_t                   state, state_nxt;
  logic [1:0]               pend, rreq, accept, drop, pend_clr;
  logic [ROM_ADDR_BITS-1:0] addr0, addr1;
  logic [2:0]               wait_cnt;
  logic                     last_grant, grant_sel, do_grant, do_capture;

  assign rreq      = {req1_rreq, req0_rreq};
  assign accept    = rreq & ~pend;
  assign drop      = rreq & pend;
  // Requester 1 wins if it is alone, or if both wait and requester 0 was served last.
  assign grant_sel = pend[1] & (~pend[0] | ~last_grant);
  // last_grant always names the requester currently in service.
  assign pend_clr  = do_capture ? (last_grant ? 2'b10 : 2'b01) : 2'b00;
  assign busy      = (state != IDLE);

  always_ff @(posedge up_clk) begin
    if (up_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    do_grant   = 1'b0;
    do_capture = 1'b0;
    case (state)
      IDLE: begin
        if (|pend) begin
          do_grant  = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt == 3'd1) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        do_capture = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge up_clk) begin
    if (up_rst) begin
      pend       <= 2'b00;
      ovf        <= 2'b00;
      last_grant <= 1'b1;
      wait_cnt   <= 3'd0;
      rom_addr   <= '0;
      req0_rack  <= 1'b0;
      req1_rack  <= 1'b0;
      req0_rdata <= '0;
      req1_rdata <= '0;
    end else begin
      pend <= (pend & ~pend_clr) | accept;
      // A fresh overflow beats a clear in the same cycle.
      ovf  <= (ovf & ~ovf_clr) | drop;
      if (do_grant) begin
        last_grant <= grant_sel;
        wait_cnt   <= 3'(ROM_LATENCY);
        rom_addr   <= grant_sel ? addr1 : addr0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt - 3'd1;
      end
      req0_rack  <= do_capture & ~last_grant;
      req1_rack  <= do_capture & last_grant;
      req0_rdata <= (do_capture & ~last_grant) ? rom_data : '0;
      req1_rdata <= (do_capture & last_grant) ? rom_data : '0;
    end
  end

  always_ff @(posedge up_clk) begin
    if (accept[0]) addr0 <= req0_raddr;
    if (accept[1]) addr1 <= req1_raddr;
  end

endmodule

// File: tb/tb_sysid_rom_arb.sv
// Scoreboard bench for sysid_rom_arb: one instance at ROM_LATENCY=1 for directed
// cases, one at ROM_LATENCY=3 for a saturated alternating stream.
`timescale 1ns/1ps
module tb_sysid_rom_arb;
  localparam int AW = 6;
  localparam int DW = 32;

  typedef struct packed { int cyc; logic r; logic [DW-1:0] d; } exp_t;
  typedef struct packed { int cyc; int inst; int kind; logic [31:0] v; } probe_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          rreq0 [2], rreq1 [2], rack0 [2], rack1 [2], busy [2];
  logic [AW-1:0] raddr0 [2], raddr1 [2], rom_addr [2];
  logic [DW-1:0] rdata0 [2], rdata1 [2], rom_data [2];
  logic [1:0]    ovf [2], ovf_clr [2];
  logic [DW-1:0] rom_pipe [2][4];
  int            cyc = 0;
  int            checks = 0;
  int            failures = 0;
  logic          done = 1'b0;
  exp_t          exp_q [2][$];
  probe_t        probes [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] rom_word(logic [AW-1:0] a);
    return 32'hA5A5_0000 | {26'd0, a};
  endfunction

  // ROM model: data follows the address by a fixed number of clocks.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      rom_pipe[i][0] <= rom_word(rom_addr[i]);
      for (int j = 1; j < 4; j++) rom_pipe[i][j] <= rom_pipe[i][j-1];
    end
  end
  assign rom_data[0] = rom_pipe[0][0];
  assign rom_data[1] = rom_pipe[1][2];

  generate
    for (genvar g = 0; g < 2; g++) begin : g_dut
      sysid_rom_arb #(.ROM_WIDTH(DW), .ROM_ADDR_BITS(AW), .ROM_LATENCY(g == 0 ? 1 : 3)) u_dut (
        .up_clk(clk), .up_rst(rst),
        .req0_rreq(rreq0[g]), .req0_raddr(raddr0[g]), .req0_rack(rack0[g]), .req0_rdata(rdata0[g]),
        .req1_rreq(rreq1[g]), .req1_raddr(raddr1[g]), .req1_rack(rack1[g]), .req1_rdata(rdata1[g]),
        .rom_addr(rom_addr[g]), .rom_data(rom_data[g]),
        .ovf(ovf[g]), .ovf_clr(ovf_clr[g]), .busy(busy[g])
      );
    end
  endgenerate

  function automatic logic [31:0] actual(int inst, int kind);
    case (kind)
      0:       return {26'd0, rom_addr[inst]};
      1:       return {31'd0, busy[inst]};
      2:       return {30'd0, ovf[inst]};
      3:       return rdata0[inst];
      4:       return rdata1[inst];
      5:       return {31'd0, rack0[inst]};
      default: return {31'd0, rack1[inst]};
    endcase
  endfunction

  function automatic string kname(int kind);
    case (kind)
      0: return "rom_addr"; 1: return "busy"; 2: return "ovf";
      3: return "rdata0"; 4: return "rdata1"; 5: return "rack0";
      default: return "rack1";
    endcase
  endfunction

  task automatic expect_ack(int inst, logic r, logic [AW-1:0] a, int c);
    exp_q[inst].push_back('{c, r, rom_word(a)});
  endtask

  task automatic probe(int c, int inst, int kind, logic [31:0] v);
    probes.push_back('{c, inst, kind, v});
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: pops the scoreboard on every acknowledge and evaluates scheduled probes.
  initial begin : monitor
    exp_t          e;
    logic          ak;
    logic [DW-1:0] dt;
    logic [31:0]   av;
    logic [1:0]    prev [2];
    prev[0] = 2'b00;
    prev[1] = 2'b00;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (rack0[i] === 1'b1 && rack1[i] === 1'b1) begin
          checks++; failures++;
          $display("FAIL ack_overlap inst%0d cyc=%0d got=both want=one", i, cyc);
        end
        for (int r = 0; r < 2; r++) begin
          ak = (r == 1) ? rack1[i] : rack0[i];
          dt = (r == 1) ? rdata1[i] : rdata0[i];
          if (ak === 1'b1) begin
            checks++;
            if (exp_q[i].size() == 0) begin
              failures++;
              $display("FAIL unexpected_ack inst%0d req%0d cyc=%0d got=%h want=none", i, r, cyc, dt);
            end else begin
              e = exp_q[i].pop_front();
              if (e.r != 1'(r) || e.d !== dt || e.cyc != cyc) begin
                failures++;
                $display("FAIL ack inst%0d got req%0d data=%h cyc=%0d want req%0d data=%h cyc=%0d",
                         i, r, dt, cyc, e.r, e.d, e.cyc);
              end
            end
          end else if (prev[i][r]) begin
            checks++;
            if (dt !== '0) begin
              failures++;
              $display("FAIL rdata_after_ack inst%0d req%0d cyc=%0d got=%h want=0", i, r, cyc, dt);
            end
          end
        end
        prev[i] = {rack1[i] === 1'b1, rack0[i] === 1'b1};
      end
      for (int p = probes.size() - 1; p >= 0; p--) begin
        if (probes[p].cyc == cyc) begin
          av = actual(probes[p].inst, probes[p].kind);
          checks++;
          if (av !== probes[p].v) begin
            failures++;
            $display("FAIL %s inst%0d cyc=%0d got=%h want=%h",
                     kname(probes[p].kind), probes[p].inst, cyc, av, probes[p].v);
          end
          probes.delete(p);
        end
      end
      if (done) begin
        for (int i = 0; i < 2; i++) begin
          checks++;
          if (exp_q[i].size() != 0) begin
            failures++;
            $display("FAIL missing_ack inst%0d got=%0d_outstanding want=0", i, exp_q[i].size());
          end
        end
        checks++;
        if (probes.size() != 0) begin
          failures++;
          $display("FAIL probes_unvisited got=%0d want=0", probes.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end

  initial begin : driver
    int            c, n0, n1, limit;
    logic [AW-1:0] a0 [500];
    logic [AW-1:0] a1 [500];
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rreq0[i] = 1'b0; rreq1[i] = 1'b0; raddr0[i] = '0; raddr1[i] = '0; ovf_clr[i] = 2'b00;
    end
    step(3);
    rst = 1'b0;
    c = cyc;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 7; k++) probe(c + 10, i, k, 32'd0);
    step(11);

    // Tie right after reset: requester 0 first, requester 1 three cycles later.
    c = cyc;
    rreq0[0] = 1'b1; raddr0[0] = 6'h10; rreq1[0] = 1'b1; raddr1[0] = 6'h11;
    expect_ack(0, 1'b0, 6'h10, c + 4);
    expect_ack(0, 1'b1, 6'h11, c + 7);
    probe(c + 2, 0, 0, 32'h10); probe(c + 2, 0, 1, 32'd1); probe(c + 5, 0, 0, 32'h11);
    step(1); rreq0[0] = 1'b0; rreq1[0] = 1'b0; step(9);

    // Isolated request on requester 0.
    c = cyc;
    rreq0[0] = 1'b1; raddr0[0] = 6'h05;
    expect_ack(0, 1'b0, 6'h05, c + 4);
    probe(c + 1, 0, 1, 32'd0); probe(c + 2, 0, 0, 32'h05); probe(c + 2, 0, 1, 32'd1);
    probe(c + 3, 0, 5, 32'd0); probe(c + 4, 0, 6, 32'd0); probe(c + 5, 0, 3, 32'd0);
    probe(c + 5, 0, 1, 32'd0);
    step(1); rreq0[0] = 1'b0; step(7);

    // Tie again with requester 0 served last: requester 1 first.
    c = cyc;
    rreq0[0] = 1'b1; raddr0[0] = 6'h20; rreq1[0] = 1'b1; raddr1[0] = 6'h21;
    expect_ack(0, 1'b1, 6'h21, c + 4);
    expect_ack(0, 1'b0, 6'h20, c + 7);
    step(1); rreq0[0] = 1'b0; rreq1[0] = 1'b0; step(9);

    // Requester 1 strobes twice in a row: second dropped, ovf[1] set, then cleared.
    c = cyc;
    rreq1[0] = 1'b1; raddr1[0] = 6'h02;
    expect_ack(0, 1'b1, 6'h02, c + 4);
    probe(c + 2, 0, 0, 32'h02); probe(c + 2, 0, 2, 32'h2); probe(c + 5, 0, 2, 32'h2);
    probe(c + 6, 0, 0, 32'h02); probe(c + 7, 0, 2, 32'h0);
    step(1); raddr1[0] = 6'h03; step(1); rreq1[0] = 1'b0; step(4);
    ovf_clr[0] = 2'b10; step(1); ovf_clr[0] = 2'b00; step(3);

    // Strobe during CAPTURE is dropped; overflow wins over a same-cycle clear.
    c = cyc;
    rreq0[0] = 1'b1; raddr0[0] = 6'h33;
    expect_ack(0, 1'b0, 6'h33, c + 4);
    probe(c + 4, 0, 2, 32'h1); probe(c + 6, 0, 0, 32'h33); probe(c + 8, 0, 2, 32'h0);
    step(1); rreq0[0] = 1'b0; step(2);
    rreq0[0] = 1'b1; raddr0[0] = 6'h34; ovf_clr[0] = 2'b01;
    step(1); rreq0[0] = 1'b0; ovf_clr[0] = 2'b00; step(3);
    ovf_clr[0] = 2'b01; step(1); ovf_clr[0] = 2'b00; step(3);

    // Reset the cycle after rom_addr issues: no ack, then a clean request.
    c = cyc;
    rreq0[0] = 1'b1; raddr0[0] = 6'h2A;
    probe(c + 2, 0, 0, 32'h2A); probe(c + 2, 0, 1, 32'd1);
    probe(c + 4, 0, 1, 32'd0); probe(c + 4, 0, 0, 32'd0);
    step(1); rreq0[0] = 1'b0; step(2);
    rst = 1'b1; step(1); rst = 1'b0; step(4);
    c = cyc;
    rreq1[0] = 1'b1; raddr1[0] = 6'h07;
    expect_ack(0, 1'b1, 6'h07, c + 4);
    probe(c + 2, 0, 0, 32'h07); probe(c + 5, 0, 2, 32'h0);
    step(1); rreq1[0] = 1'b0; step(7);

    // Saturated stream at ROM_LATENCY=3: each requester re-strobes on its ack.
    for (int n = 0; n < 500; n++) begin
      a0[n] = 6'($urandom);
      a1[n] = 6'($urandom);
    end
    c = cyc;
    for (int n = 0; n < 1000; n++)
      expect_ack(1, 1'(n % 2), (n % 2 == 1) ? a1[n/2] : a0[n/2], c + 6 + 5 * n);
    rreq0[1] = 1'b1; raddr0[1] = a0[0]; rreq1[1] = 1'b1; raddr1[1] = a1[0];
    n0 = 1; n1 = 1;
    limit = c + 6 + 5 * 1000 + 20;
    while (exp_q[1].size() != 0 && cyc < limit) begin
      step(1);
      rreq0[1] = 1'b0; rreq1[1] = 1'b0;
      if (rack0[1] === 1'b1 && n0 < 500) begin
        rreq0[1] = 1'b1; raddr0[1] = a0[n0]; n0++;
      end
      if (rack1[1] === 1'b1 && n1 < 500) begin
        rreq1[1] = 1'b1; raddr1[1] = a1[n1]; n1++;
      end
    end
    rreq0[1] = 1'b0; rreq1[1] = 1'b0;
    step(5);
    done = 1'b1;
    step(5);
    $display("FAIL monitor_stall got=running want=finished");
    $fatal(1);
  end

endmodule
